// File: rtl/axi_h2c_read.sv
// -----------------------------------------------------------------------------
// axi_h2c_read
//   AXI4-Stream H2C receiver. Collects BEATS consecutive DATA_W-bit beats from
//   the XDMA H2C stream into one REC_W-bit record (beat 0 in the LSBs) and
//   offers the completed record to user logic on a valid/ready handshake.
//   The stream is back-pressured while a record is held, which costs one
//   ready bubble per record.
//
// Configuration macro:
//   TLAST_CHECK_EN  when defined, tlast frames records: an early tlast closes
//                   the record (unfilled slots zeroed) and a missing tlast on
//                   the last beat is flagged; both pulse err_len. When
//                   undefined, tlast is ignored and err_len stays 0.
//
// Ports:
//   m_axis_c2h_aclk     clock
//   m_axis_c2h_aresetn  asynchronous reset, active-low
//   clr                 synchronous flush, active-high, overrides everything
//   s_axis_h2c_*        H2C stream slave (tkeep ignored, full beats assumed)
//   rec_data/valid/ready  assembled record handshake
//   err_len             1-cycle pulse on tlast/length mismatch
//   rec_count           records delivered (wraps)
//   sstate, beat_cnt    debug: FSM state and beats collected so far
// -----------------------------------------------------------------------------
module axi_h2c_read #(
  parameter  int DATA_W = 512,
  parameter  int BEATS  = 8,
  parameter  int CNT_W  = 16,
  localparam int REC_W  = BEATS * DATA_W,
  localparam int BC_W   = $clog2(BEATS)
) (
  input  logic                m_axis_c2h_aclk,
  input  logic                m_axis_c2h_aresetn,
  input  logic                clr,
  input  logic [DATA_W-1:0]   s_axis_h2c_tdata,
  input  logic [DATA_W/8-1:0] s_axis_h2c_tkeep,
  input  logic                s_axis_h2c_tlast,
  input  logic                s_axis_h2c_tvalid,
  output logic                s_axis_h2c_tready,
  output logic [REC_W-1:0]    rec_data,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic                err_len,
  output logic [CNT_W-1:0]    rec_count,
  output logic [1:0]          sstate,
  output logic [BC_W-1:0]     beat_cnt
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1
  } state_t;

  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  state_t            state_r;
  logic [BC_W-1:0]   beat_cnt_r;
  logic              rec_valid_r;
  logic              err_len_r;
  logic [CNT_W-1:0]  rec_count_r;
  logic [REC_W-1:0]  rec_data_r;

  logic beat_acc_s;
  logic last_beat_s;
  logic rec_done_s;
  logic len_err_s;
  logic zero_fill_s;
  logic unused_ok_s;

  // tready comes straight from the registered state: no path from tvalid/rec_ready.
  assign s_axis_h2c_tready = (state_r == COLLECT);
  assign beat_acc_s        = s_axis_h2c_tvalid && (state_r == COLLECT);
  assign last_beat_s       = (beat_cnt_r == LAST_BEAT);

`ifdef TLAST_CHECK_EN
  // A record closes on the counted last beat or on tlast, whichever comes first.
  // Mismatch exactly when tlast disagrees with "this is the last slot".
  assign rec_done_s  = last_beat_s || s_axis_h2c_tlast;
  assign len_err_s   = last_beat_s ^ s_axis_h2c_tlast;
  assign zero_fill_s = s_axis_h2c_tlast;
`else
  assign rec_done_s  = last_beat_s;
  assign len_err_s   = 1'b0;
  assign zero_fill_s = 1'b0;
`endif

  // tkeep is ignored by design; tlast is ignored in the counting-only build.
  assign unused_ok_s = ^{s_axis_h2c_tkeep, s_axis_h2c_tlast};

  // Control FSM: framing, record handshake, error pulse and delivery counter.
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      state_r     <= COLLECT;
      beat_cnt_r  <= '0;
      rec_valid_r <= 1'b0;
      err_len_r   <= 1'b0;
      rec_count_r <= '0;
    end else if (clr) begin
      state_r     <= COLLECT;
      beat_cnt_r  <= '0;
      rec_valid_r <= 1'b0;
      err_len_r   <= 1'b0;
      rec_count_r <= '0;
    end else begin
      err_len_r <= 1'b0;
      case (state_r)
        COLLECT: begin
          if (beat_acc_s) begin
            if (rec_done_s) begin
              rec_valid_r <= 1'b1;
              err_len_r   <= len_err_s;
              beat_cnt_r  <= '0;
              state_r     <= HOLD;
            end else begin
              beat_cnt_r  <= beat_cnt_r + BC_W'(1);
            end
          end
        end
        HOLD: begin
          if (rec_ready) begin
            rec_valid_r <= 1'b0;
            rec_count_r <= rec_count_r + CNT_W'(1);
            state_r     <= COLLECT;
          end
        end
        default: begin
          state_r     <= COLLECT;
          beat_cnt_r  <= '0;
          rec_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Record datapath: no reset needed, contents are only meaningful with rec_valid.
  // On an early tlast every slot above the current one is zeroed in the same cycle.
  always_ff @(posedge m_axis_c2h_aclk) begin
    if (!clr && beat_acc_s) begin
      for (int i = 0; i < BEATS; i++) begin
        if (BC_W'(i) == beat_cnt_r) begin
          rec_data_r[i*DATA_W +: DATA_W] <= s_axis_h2c_tdata;
        end else if (zero_fill_s && (BC_W'(i) > beat_cnt_r)) begin
          rec_data_r[i*DATA_W +: DATA_W] <= '0;
        end
      end
    end
  end

  assign rec_data  = rec_data_r;
  assign rec_valid = rec_valid_r;
  assign err_len   = err_len_r;
  assign rec_count = rec_count_r;
  assign sstate    = state_r;
  assign beat_cnt  = beat_cnt_r;

endmodule

// File: tb/tb_axi_h2c_read.sv
// -----------------------------------------------------------------------------
// tb_axi_h2c_read
//   Drives randomized and directed H2C traffic into axi_h2c_read and compares
//   every output against a queue-based record model once per cycle.
// -----------------------------------------------------------------------------
module tb_axi_h2c_read;

  localparam int DW = 512;
  localparam int NB = 8;
  localparam int RW = DW * NB;
`ifdef TLAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [63:0]   tkeep = '1;
  logic          tlast = 1'b0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [RW-1:0] rec_data;
  logic          rec_valid;
  logic          rec_ready = 1'b0;
  logic          err_len;
  logic [15:0]   rec_count;
  logic [1:0]    sstate;
  logic [2:0]    beat_cnt;

  axi_h2c_read dut (
    .m_axis_c2h_aclk    (clk),
    .m_axis_c2h_aresetn (aresetn),
    .clr                (clr),
    .s_axis_h2c_tdata   (tdata),
    .s_axis_h2c_tkeep   (tkeep),
    .s_axis_h2c_tlast   (tlast),
    .s_axis_h2c_tvalid  (tvalid),
    .s_axis_h2c_tready  (tready),
    .rec_data           (rec_data),
    .rec_valid          (rec_valid),
    .rec_ready          (rec_ready),
    .err_len            (err_len),
    .rec_count          (rec_count),
    .sstate             (sstate),
    .beat_cnt           (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: beats of the record in progress, the held record, counters.
  logic [DW-1:0] cur[$];
  logic [RW-1:0] exp_rec = '0;
  bit            pending = 1'b0;
  bit            exp_err = 1'b0;
  logic [15:0]   m_count = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    cur.delete();
    pending = 1'b0;
    exp_err = 1'b0;
    m_count = '0;
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit l, input bit rr, input bit c);
    @(negedge clk);
    chk("tready",    {511'd0, tready},    {511'd0, !pending});
    chk("rec_valid", {511'd0, rec_valid}, {511'd0, pending});
    chk("sstate",    {510'd0, sstate},    {510'd0, 1'b0, pending});
    chk("beat_cnt",  {509'd0, beat_cnt},  DW'(cur.size()));
    chk("err_len",   {511'd0, err_len},   {511'd0, exp_err});
    chk("rec_count", {496'd0, rec_count}, {496'd0, m_count});
    tvalid    = v;
    tdata     = d;
    tlast     = l;
    rec_ready = rr;
    clr       = c;
    exp_err   = 1'b0;
    if (c) begin
      model_clear();
    end else if (pending) begin
      if (rr) begin
        for (int k = 0; k < NB; k++)
          chk("rec_slot", rec_data[k*DW +: DW], exp_rec[k*DW +: DW]);
        pending = 1'b0;
        m_count = m_count + 16'd1;
      end
    end else if (v) begin
      cur.push_back(d);
      if (cur.size() == NB || (CHK && l)) begin
        exp_rec = '0;
        foreach (cur[k]) exp_rec[k*DW +: DW] = cur[k];
        exp_err = CHK && ((cur.size() == NB) ? !l : 1'b1);
        pending = 1'b1;
        cur.delete();
      end
    end
  endtask

  // Offer one beat until it is taken; a beat that never gets in is a failure.
  task automatic send_beat(input logic [DW-1:0] d, input bit l, input bit rr);
    bit ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      bit was_free = !pending;
      cyc(1'b1, d, l, rr, 1'b0);
      if (was_free) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", DW'(0), DW'(1));
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, rr, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [7:0]    kb;
    int            n;
    int            guard;

    // Reset state, checked by the first idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    idle(2, 1'b0);

    // T1: patterned record, tlast on beat 7, consumer always ready.
    for (int k = 0; k < NB; k++) begin
      kb = 8'(k);
      send_beat({64{kb}}, (k == NB - 1), 1'b1);
    end
    idle(3, 1'b1);

    // T2: two records, consumer stalls 10 cycles while the source keeps pushing.
    for (int k = 0; k < NB; k++) send_beat(rnd_beat(), (k == NB - 1), 1'b0);
    d = rnd_beat();
    for (int i = 0; i < 10; i++) cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
    send_beat(d, 1'b0, 1'b1);
    for (int k = 1; k < NB; k++) send_beat(rnd_beat(), (k == NB - 1), 1'b1);
    idle(3, 1'b1);

    // T3: random tvalid and rec_ready over three records.
    n = 0;
    guard = 0;
    d = rnd_beat();
    while (n < 3 * NB && guard < 2000) begin
      bit v;
      bit acc;
      v   = 1'($urandom % 2);
      acc = v && !pending;
      cyc(v, d, (n % NB == NB - 1), 1'($urandom % 2), 1'b0);
      if (acc) begin
        n++;
        d = rnd_beat();
      end
      guard++;
    end
    if (n < 3 * NB) chk("t3_timeout", DW'(n), DW'(3 * NB));
    idle(4, 1'b1);

    // T4/T5: tlast on beat 3, then a normally framed record.
    for (int k = 0; k < 4; k++) send_beat(rnd_beat(), (k == 3), 1'b1);
    idle(2, 1'b1);
    for (int k = 0; k < NB; k++) send_beat(rnd_beat(), (k == NB - 1), 1'b1);
    idle(2, 1'b1);

    // Missing tlast on a full record.
    for (int k = 0; k < NB; k++) send_beat(rnd_beat(), 1'b0, 1'b1);
    idle(2, 1'b1);

    // T6: clr after beat 4 (with a beat offered in the clr cycle), then 8 fresh beats.
    for (int k = 0; k < 5; k++) send_beat(rnd_beat(), 1'b0, 1'b1);
    cyc(1'b1, rnd_beat(), 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < NB; k++) send_beat(rnd_beat(), (k == NB - 1), 1'b1);
    idle(3, 1'b1);

    // Async reset mid-record, then a full record.
    for (int k = 0; k < 3; k++) send_beat(rnd_beat(), 1'b0, 1'b1);
    @(negedge clk);
    tvalid  = 1'b0;
    clr     = 1'b0;
    aresetn = 1'b0;
    model_clear();
    #3;
    chk("async_rst_valid", {511'd0, rec_valid}, DW'(0));
    chk("async_rst_cnt",   {509'd0, beat_cnt},  DW'(0));
    @(negedge clk);
    aresetn = 1'b1;
    for (int k = 0; k < NB; k++) send_beat(rnd_beat(), (k == NB - 1), 1'b1);
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
